fft_ifft_frame_ctrl: RTL and testbench
======================================

Name: fft_ifft_frame_ctrl

Overview:
Parametrised frame controller between the codec sample stream and the external FFT → spectral-process → IFFT chain. Frames codec samples into a ping-pong input buffer and streams each full frame to the FFT. Accepts the IFFT result stream and rescales every sample using the combined FFT/IFFT block exponents, saturating to sample width. Stores the result in a ping-pong output buffer and plays it back one sample per codec strobe, with sticky overrun/underrun/framing flags.

Parameters:
DATA_W, 18, sample width (codec, FFT input and IFFT output real part).
LOG2_N, 9, log2 frame length; N = 2**LOG2_N.
SCALE_W, 4, width of each block-exponent input.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle codec sample strobe
sample_in  in  DATA_W  signed codec sample, valid with sample_valid
sample_out  out  DATA_W  signed playback sample, registered
fwd_valid  out  1  frame sample to FFT valid
fwd_ready  in  1  FFT accepts sample
fwd_data  out  DATA_W  frame sample to FFT
fwd_last  out  1  marks sample N-1 of the frame
inv_valid  in  1  IFFT real output valid
inv_ready  out  1  block accepts IFFT sample
inv_data  in  DATA_W  signed IFFT real output
inv_last  in  1  IFFT marks last sample of the frame
fft_scale  in  SCALE_W  FFT block exponent, held constant for the frame
ifft_scale  in  SCALE_W  IFFT block exponent, held constant for the frame
overrun  out  1  sticky: input frame dropped
underrun  out  1  sticky: playback had no frame
frame_err  out  1  sticky: inv_last did not coincide with beat N-1

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Reset clears all outputs to 0, all bank-full flags, all indices and bank selects, the playing flag, and sets the FSM to IDLE. Reset mid-frame discards all buffered data.
- Input side, on sample_valid:
  - Write in_buf[wr_bank][wr_idx], then increment wr_idx.
  - At wr_idx = N-1, wr_idx wraps to 0.
  - If the bank !wr_bank is not full: set in_full[wr_bank] and toggle wr_bank.
  - Otherwise: set overrun, do not set in_full, keep wr_bank (the frame is discarded and that bank is rewritten).
- Send FSM, IDLE → SEND → WAIT:
  - IDLE: move to SEND when in_full[snd_bank]; snd_idx = 0.
  - SEND: fwd_valid = 1. fwd_data = in_buf[snd_bank][snd_idx] (combinational array read). fwd_last = (snd_idx = N-1).
  - SEND: on fwd_valid & fwd_ready, increment snd_idx. On the last beat, clear in_full[snd_bank], toggle snd_bank, go to WAIT.
  - WAIT: leave for IDLE on the cycle the Nth inv beat is accepted.
  - fwd_* are 0 outside SEND.
  - If in_full and a wrap of the same bank occur in the same cycle, the clear wins for that bank.
- Receive:
  - inv_ready = (state = WAIT) & !out_full[fil_bank].
  - Each accepted beat is rescaled and written to out_buf[fil_bank][fil_idx] one cycle later (one pipeline register).
  - The frame closes on the Nth beat regardless of inv_last. Closing sets out_full[fil_bank], toggles fil_bank and resets fil_idx.
  - inv_last on any beat other than N-1, or absent on beat N-1, sets frame_err.
- Rescale:
  - sh = fft_scale + ifft_scale − LOG2_N, signed, width SCALE_W+2.
  - sh ≥ 0: left shift by sh, saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - sh < 0: arithmetic right shift by −sh, truncating toward −∞.
- Playback, on sample_valid:
  - If out_full[rd_bank]: sample_out ← out_buf[rd_bank][rd_idx], rd_idx increments, and playing is set.
  - At rd_idx = N-1: clear out_full[rd_bank] and toggle rd_bank.
  - If !out_full[rd_bank]: sample_out ← 0. Set underrun only if playing is already 1 (silence before the first frame is not an error).
  - A same-cycle set by the receive side and playback check sees the old flag.
- Latency: the first non-zero sample_out occurs at the first sample_valid after the first output frame closes.

Decomposition:
- Package fft_ifft_frame_pkg: FSM state enum (IDLE, SEND, WAIT), saturating-shift function, derived constant N.
- Sub-module frame_rescaler: the combinational shift/saturate plus its pipeline register, parametrised by DATA_W, SCALE_W and LOG2_N.

Test Plan (LOG2_N = 3, DATA_W = 18, fwd_ready = 1, IFFT model loops fwd back as inv with fft_scale = 3 and ifft_scale = 0):
- Reset, then 8 strobes of 1..8 → fwd_valid burst of 1..8 with fwd_last on 8. After the loopback, the next 8 strobes give sample_out 1..8. No flags set.
- fft_scale = 5, ifft_scale = 0, inv_data = 100000 → sh = 2, output saturates to 131071. inv_data = −100000 → −131072.
- fft_scale = 1, ifft_scale = 0, inv_data = −5 → sh = −2, output −2.
- Hold fwd_ready = 0 while 24 strobes arrive → overrun = 1 after the 24th strobe. The first frame is still sent intact once fwd_ready = 1.
- Stop the IFFT model after the first frame plays → next strobe gives sample_out = 0 and underrun = 1. Strobes before the first frame leave underrun = 0.
- Assert inv_last on beat 5 → frame_err = 1. The frame still closes after 8 beats.
- Assert reset mid-SEND → all outputs 0, fwd_valid drops immediately, and a fresh frame streams normally afterwards.

Source files
------------

// File: rtl/fft_ifft_frame_pkg.sv
// Shared definitions for the FFT/IFFT frame controller.
//   snd_state_e : send-side FSM states
//   frame_len   : frame length N from log2 frame length
//   sat_shift   : signed shift (left saturating / right flooring) to a target width
package fft_ifft_frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } snd_state_e;

  function automatic int frame_len(input int log2_n);
    return 1 << log2_n;
  endfunction

  // Positive sh shifts left and clamps to a data_w-bit signed range; negative sh is an
  // arithmetic right shift, which floors toward minus infinity.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x,
                                                    input int sh, input int data_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] y;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sh >= 0) begin
      // Beyond this shift any non-zero input is out of range anyway.
      if (sh > 63 - data_w) begin
        y = (x == 64'sd0) ? 64'sd0 : ((x < 64'sd0) ? min_v : max_v);
      end else begin
        y = x <<< sh;
      end
      if (y > max_v) y = max_v;
      else if (y < min_v) y = min_v;
    end else if (-sh > 63) begin
      y = (x < 64'sd0) ? -64'sd1 : 64'sd0;
    end else begin
      y = x >>> (-sh);
    end
    return y;
  endfunction

endpackage

// File: rtl/fft_ifft_frame_ctrl_rescaler.sv
// frame_rescaler: applies the combined FFT/IFFT block exponent to one IFFT sample and
// registers the result.
//   clk, reset             : clock, asynchronous active-high reset
//   in_valid, in_data      : accepted IFFT beat
//   fft_scale, ifft_scale  : block exponents, stable for the frame
//   out_valid, out_data    : rescaled, saturated sample one cycle later
module frame_rescaler
  import fft_ifft_frame_pkg::*;
#(
  parameter int DATA_W  = 18,
  parameter int SCALE_W = 4,
  parameter int LOG2_N  = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SCALE_W-1:0] fft_scale,
  input  logic [SCALE_W-1:0] ifft_scale,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data
);

  localparam logic signed [SCALE_W+1:0] LogN = (SCALE_W + 2)'(LOG2_N);

  logic signed [SCALE_W+1:0] sh;
  logic                      out_valid_d, out_valid_q;
  logic [DATA_W-1:0]         out_data_d, out_data_q;

  always_comb begin
    // Two guard bits keep the sum of two unsigned exponents minus LOG2_N from wrapping.
    sh          = $signed({2'b00, fft_scale}) + $signed({2'b00, ifft_scale}) - LogN;
    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    if (in_valid) begin
      out_data_d = DATA_W'(sat_shift(64'($signed(in_data)), int'(sh), DATA_W));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/fft_ifft_frame_ctrl.sv
// fft_ifft_frame_ctrl: frames codec samples into a ping-pong input buffer, streams full
// frames to the FFT, rescales the returning IFFT stream into a ping-pong output buffer and
// plays it back one sample per codec strobe.
//   clk, reset                  : clock, asynchronous active-high reset
//   sample_valid, sample_in     : codec sample strobe and data
//   sample_out                  : registered playback sample
//   fwd_valid/ready/data/last   : frame stream to the FFT
//   inv_valid/ready/data/last   : IFFT real-part stream back
//   fft_scale, ifft_scale       : block exponents for the frame being received
//   overrun, underrun, frame_err: sticky status flags
module fft_ifft_frame_ctrl
  import fft_ifft_frame_pkg::*;
#(
  parameter int DATA_W  = 18,
  parameter int LOG2_N  = 9,
  parameter int SCALE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  sample_in,
  output logic [DATA_W-1:0]  sample_out,
  output logic               fwd_valid,
  input  logic               fwd_ready,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               fwd_last,
  input  logic               inv_valid,
  output logic               inv_ready,
  input  logic [DATA_W-1:0]  inv_data,
  input  logic               inv_last,
  input  logic [SCALE_W-1:0] fft_scale,
  input  logic [SCALE_W-1:0] ifft_scale,
  output logic               overrun,
  output logic               underrun,
  output logic               frame_err
);

  localparam int N = frame_len(LOG2_N);
  localparam logic [LOG2_N-1:0] LastIdx = LOG2_N'(N - 1);
  localparam logic [LOG2_N-1:0] IdxOne  = LOG2_N'(1);

  logic [DATA_W-1:0] in_mem  [2][N];
  logic [DATA_W-1:0] out_mem [2][N];

  snd_state_e        state_d, state_q;
  logic [LOG2_N-1:0] wr_idx_d, wr_idx_q, snd_idx_d, snd_idx_q;
  logic [LOG2_N-1:0] fil_idx_d, fil_idx_q, rd_idx_d, rd_idx_q, pipe_idx_d, pipe_idx_q;
  logic              wr_bank_d, wr_bank_q, snd_bank_d, snd_bank_q;
  logic              fil_bank_d, fil_bank_q, rd_bank_d, rd_bank_q, pipe_bank_d, pipe_bank_q;
  logic [1:0]        in_full_d, in_full_q, out_full_d, out_full_q;
  logic              playing_d, playing_q;
  logic              overrun_d, overrun_q, underrun_d, underrun_q, frame_err_d, frame_err_q;
  logic [DATA_W-1:0] sample_out_d, sample_out_q;
  logic              inv_fire, fil_last;
  logic              resc_valid;
  logic [DATA_W-1:0] resc_data;

  assign inv_ready = (state_q == StWait) && !out_full_q[fil_bank_q];
  assign inv_fire  = inv_valid && inv_ready;
  assign fil_last  = (fil_idx_q == LastIdx);

  always_comb begin
    fwd_valid = (state_q == StSend);
    fwd_last  = fwd_valid && (snd_idx_q == LastIdx);
    fwd_data  = fwd_valid ? in_mem[snd_bank_q][snd_idx_q] : '0;
  end

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    wr_bank_d    = wr_bank_q;
    snd_idx_d    = snd_idx_q;
    snd_bank_d   = snd_bank_q;
    fil_idx_d    = fil_idx_q;
    fil_bank_d   = fil_bank_q;
    rd_idx_d     = rd_idx_q;
    rd_bank_d    = rd_bank_q;
    pipe_idx_d   = pipe_idx_q;
    pipe_bank_d  = pipe_bank_q;
    in_full_d    = in_full_q;
    out_full_d   = out_full_q;
    playing_d    = playing_q;
    overrun_d    = overrun_q;
    underrun_d   = underrun_q;
    frame_err_d  = frame_err_q;
    sample_out_d = sample_out_q;

    // Input framing: a completed frame is only handed over if the other bank is free,
    // otherwise it is dropped and the same bank is refilled.
    if (sample_valid) begin
      wr_idx_d = wr_idx_q + IdxOne;
      if (wr_idx_q == LastIdx) begin
        if (!in_full_q[~wr_bank_q]) begin
          in_full_d[wr_bank_q] = 1'b1;
          wr_bank_d            = ~wr_bank_q;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    // Send FSM; the clear below comes after the set so it wins on a same-bank collision.
    unique case (state_q)
      StIdle: begin
        if (in_full_q[snd_bank_q]) begin
          state_d   = StSend;
          snd_idx_d = '0;
        end
      end
      StSend: begin
        if (fwd_ready) begin
          snd_idx_d = snd_idx_q + IdxOne;
          if (snd_idx_q == LastIdx) begin
            in_full_d[snd_bank_q] = 1'b0;
            snd_bank_d            = ~snd_bank_q;
            state_d               = StWait;
          end
        end
      end
      StWait: begin
        if (inv_fire && fil_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Receive: frame closes on beat N-1 by count; inv_last only feeds the error flag.
    if (inv_fire) begin
      pipe_idx_d  = fil_idx_q;
      pipe_bank_d = fil_bank_q;
      fil_idx_d   = fil_idx_q + IdxOne;
      if (fil_last != inv_last) frame_err_d = 1'b1;
      if (fil_last) begin
        out_full_d[fil_bank_q] = 1'b1;
        fil_bank_d             = ~fil_bank_q;
      end
    end

    // Playback looks at the registered flag, so a frame closing this cycle is not yet seen.
    if (sample_valid) begin
      if (out_full_q[rd_bank_q]) begin
        sample_out_d = out_mem[rd_bank_q][rd_idx_q];
        rd_idx_d     = rd_idx_q + IdxOne;
        playing_d    = 1'b1;
        if (rd_idx_q == LastIdx) begin
          out_full_d[rd_bank_q] = 1'b0;
          rd_bank_d             = ~rd_bank_q;
        end
      end else begin
        sample_out_d = '0;
        if (playing_q) underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_idx_q     <= '0;
      wr_bank_q    <= 1'b0;
      snd_idx_q    <= '0;
      snd_bank_q   <= 1'b0;
      fil_idx_q    <= '0;
      fil_bank_q   <= 1'b0;
      rd_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      pipe_idx_q   <= '0;
      pipe_bank_q  <= 1'b0;
      in_full_q    <= '0;
      out_full_q   <= '0;
      playing_q    <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      sample_out_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      wr_bank_q    <= wr_bank_d;
      snd_idx_q    <= snd_idx_d;
      snd_bank_q   <= snd_bank_d;
      fil_idx_q    <= fil_idx_d;
      fil_bank_q   <= fil_bank_d;
      rd_idx_q     <= rd_idx_d;
      rd_bank_q    <= rd_bank_d;
      pipe_idx_q   <= pipe_idx_d;
      pipe_bank_q  <= pipe_bank_d;
      in_full_q    <= in_full_d;
      out_full_q   <= out_full_d;
      playing_q    <= playing_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      frame_err_q  <= frame_err_d;
      sample_out_q <= sample_out_d;
    end
  end

  // Sample storage carries no reset; the bank-full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (sample_valid) in_mem[wr_bank_q][wr_idx_q] <= sample_in;
    if (resc_valid) out_mem[pipe_bank_q][pipe_idx_q] <= resc_data;
  end

  frame_rescaler #(
    .DATA_W (DATA_W),
    .SCALE_W(SCALE_W),
    .LOG2_N (LOG2_N)
  ) u_rescaler (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inv_fire),
    .in_data   (inv_data),
    .fft_scale (fft_scale),
    .ifft_scale(ifft_scale),
    .out_valid (resc_valid),
    .out_data  (resc_data)
  );

  assign sample_out = sample_out_q;
  assign overrun    = overrun_q;
  assign underrun   = underrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_ifft_frame_ctrl.sv
// Bench for fft_ifft_frame_ctrl with N = 8: loops the FFT stream back as IFFT data and
// checks framing, rescaling, playback and the status flags against a reference model.
module tb_fft_ifft_frame_ctrl;
  localparam int DW  = 18;
  localparam int L2N = 3;
  localparam int SW  = 4;
  localparam int N   = 8;
  localparam longint MaxV = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint MinV = -MaxV - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [DW-1:0] sample_out;
  logic          fwd_valid, fwd_last;
  logic          fwd_ready = 1'b1;
  logic [DW-1:0] fwd_data;
  logic          inv_valid = 1'b0;
  logic          inv_ready;
  logic [DW-1:0] inv_data = '0;
  logic          inv_last = 1'b0;
  logic [SW-1:0] fft_scale = 4'd3;
  logic [SW-1:0] ifft_scale = 4'd0;
  logic          overrun, underrun, frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] cap_data  [N];
  logic [N-1:0]  cap_last;
  logic [DW-1:0] inv_frame [N];
  logic [DW-1:0] in_frame  [N];
  logic [DW-1:0] exp_frame [N];

  always #5 clk = ~clk;

  fft_ifft_frame_ctrl #(
    .DATA_W (DW),
    .LOG2_N (L2N),
    .SCALE_W(SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .sample_out  (sample_out),
    .fwd_valid   (fwd_valid),
    .fwd_ready   (fwd_ready),
    .fwd_data    (fwd_data),
    .fwd_last    (fwd_last),
    .inv_valid   (inv_valid),
    .inv_ready   (inv_ready),
    .inv_data    (inv_data),
    .inv_last    (inv_last),
    .fft_scale   (fft_scale),
    .ifft_scale  (ifft_scale),
    .overrun     (overrun),
    .underrun    (underrun),
    .frame_err   (frame_err)
  );

  // Output = x * 2^(fs+isc-LOG2_N), floored, clamped to the signed DW-bit range.
  function automatic logic [DW-1:0] ref_rescale(input logic [DW-1:0] x, input int fs,
                                                input int isc);
    longint v, p, q;
    int sh, mag;
    v   = longint'($signed(x));
    sh  = fs + isc - L2N;
    mag = (sh < 0) ? -sh : sh;
    p   = 1;
    for (int i = 0; i < mag; i++) p = p * 2;
    if (sh >= 0) begin
      q = v * p;
    end else begin
      q = v / p;
      if ((v % p) != 0 && v < 0) q = q - 1;
    end
    if (q > MaxV) q = MaxV;
    if (q < MinV) q = MinV;
    return DW'(q);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 1'b0; sample_in = '0; fwd_ready = 1'b1;
    inv_valid = 1'b0; inv_data = '0; inv_last = 1'b0; fft_scale = 4'd3; ifft_scale = 4'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // One-cycle strobe after an idle cycle; returns on the negedge after the capturing edge.
  task automatic strobe(input logic [DW-1:0] v);
    tick();
    sample_in = v; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic collect_fwd(output bit ok);
    int cnt;
    cnt = 0; cap_last = '0;
    for (int i = 0; i < N; i++) cap_data[i] = '0;
    for (int cyc = 0; cyc < 200 && cnt < N; cyc++) begin
      if (fwd_valid && fwd_ready) begin
        cap_data[cnt] = fwd_data; cap_last[cnt] = fwd_last; cnt++;
      end
      tick();
    end
    ok = (cnt == N);
  endtask

  task automatic send_inv(input int last_pos, output bit ok);
    int w;
    ok = 1'b1;
    for (int b = 0; b < N; b++) begin
      inv_valid = 1'b1; inv_data = inv_frame[b]; inv_last = (b == last_pos);
      w = 0;
      while (!inv_ready && w < 100) begin tick(); w++; end
      if (!inv_ready) ok = 1'b0;
      tick();
    end
    inv_valid = 1'b0; inv_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({sample_out, fwd_valid, fwd_data, fwd_last, inv_ready, overrun, underrun, frame_err}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fwd_valid=%b inv_ready=%b sample_out=%0d flags=%b%b%b, required all 0",
               fwd_valid, inv_ready, sample_out, overrun, underrun, frame_err);
    end
    do_reset();
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) begin
      strobe(DW'(i + 1));
      n_checks++;
      if (sample_out !== '0) begin
        n_fail++; $display("FAIL basic_silence[%0d]: got %0d required 0", i, sample_out);
      end
    end
    collect_fwd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_fwd_timeout: got %0b required 1", ok); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cap_data[i] !== DW'(i + 1)) begin
        n_fail++; $display("FAIL basic_fwd_data[%0d]: got %0d required %0d", i, cap_data[i], i + 1);
      end
    end
    n_checks++;
    if (cap_last !== 8'h80) begin
      n_fail++; $display("FAIL basic_fwd_last: got %b required 10000000", cap_last);
    end
    for (int i = 0; i < N; i++) inv_frame[i] = cap_data[i];
    send_inv(N - 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_inv_timeout: got %0b required 1", ok); end
    for (int i = 0; i < N; i++) begin
      strobe(DW'(i + 9));
      n_checks++;
      if (sample_out !== DW'(i + 1)) begin
        n_fail++; $display("FAIL basic_play[%0d]: got %0d required %0d", i, sample_out, i + 1);
      end
    end
    n_checks++;
    if ({overrun, underrun, frame_err} !== 3'b000) begin
      n_fail++; $display("FAIL basic_flags: got %b required 000", {overrun, underrun, frame_err});
    end
  endtask

  task automatic test_rescale();
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) strobe(DW'($urandom));
    collect_fwd(ok);
    fft_scale = 4'd5;
    inv_frame[0] = DW'(100000);  inv_frame[1] = DW'(-100000); inv_frame[2] = DW'(3);
    inv_frame[3] = DW'(-3);      inv_frame[4] = DW'(32767);   inv_frame[5] = DW'(32768);
    inv_frame[6] = DW'(-32768);  inv_frame[7] = DW'(-32769);
    for (int i = 0; i < N; i++) exp_frame[i] = ref_rescale(inv_frame[i], 5, 0);
    send_inv(N - 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sat_inv_timeout: got %0b required 1", ok); end
    fft_scale = 4'd3;
    for (int i = 0; i < N; i++) begin
      strobe(DW'($urandom));
      n_checks++;
      if (sample_out !== exp_frame[i]) begin
        n_fail++; $display("FAIL sat_play[%0d]: got %0d required %0d", i,
                           $signed(sample_out), $signed(exp_frame[i]));
      end
      if (i == 0) begin
        n_checks++;
        if (sample_out !== 18'd131071) begin
          n_fail++; $display("FAIL sat_pos: got %0d required 131071", $signed(sample_out));
        end
      end
      if (i == 1) begin
        n_checks++;
        if (sample_out !== 18'h20000) begin
          n_fail++; $display("FAIL sat_neg: got %0d required -131072", $signed(sample_out));
        end
      end
    end
    collect_fwd(ok);
    fft_scale = 4'd1;
    inv_frame[0] = DW'(-5);  inv_frame[1] = DW'(5);   inv_frame[2] = DW'(-1);
    inv_frame[3] = DW'(7);   inv_frame[4] = DW'(-8);  inv_frame[5] = DW'(-9);
    inv_frame[6] = DW'(131071); inv_frame[7] = DW'(-131072);
    for (int i = 0; i < N; i++) exp_frame[i] = ref_rescale(inv_frame[i], 1, 0);
    send_inv(N - 1, ok);
    fft_scale = 4'd3;
    for (int i = 0; i < N; i++) begin
      strobe(DW'($urandom));
      n_checks++;
      if (sample_out !== exp_frame[i]) begin
        n_fail++; $display("FAIL shr_play[%0d]: got %0d required %0d", i,
                           $signed(sample_out), $signed(exp_frame[i]));
      end
      if (i == 0) begin
        n_checks++;
        if (sample_out !== 18'h3FFFE) begin
          n_fail++; $display("FAIL shr_floor: got %0d required -2", $signed(sample_out));
        end
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    fwd_ready = 1'b0;
    for (int i = 0; i < N; i++) strobe(DW'(i + 1));
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b required 0", overrun); end
    for (int i = N; i < 3 * N; i++) strobe(DW'(i + 1));
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b required 1", overrun); end
    fwd_ready = 1'b1;
    collect_fwd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL overrun_fwd_timeout: got %0b required 1", ok); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cap_data[i] !== DW'(i + 1)) begin
        n_fail++; $display("FAIL overrun_frame[%0d]: got %0d required %0d", i, cap_data[i], i + 1);
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) begin
      in_frame[i] = DW'($urandom);
      strobe(in_frame[i]);
    end
    n_checks++;
    if ({underrun, sample_out} !== '0) begin
      n_fail++; $display("FAIL underrun_before_first: got underrun=%b sample_out=%0d required 0/0",
                         underrun, sample_out);
    end
    collect_fwd(ok);
    for (int i = 0; i < N; i++) inv_frame[i] = cap_data[i];
    send_inv(N - 1, ok);
    for (int i = 0; i < N; i++) begin
      strobe(DW'($urandom));
      n_checks++;
      if (sample_out !== in_frame[i]) begin
        n_fail++; $display("FAIL underrun_play[%0d]: got %0d required %0d", i, sample_out, in_frame[i]);
      end
    end
    n_checks++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_early: got %b required 0", underrun); end
    strobe(DW'(77));
    n_checks++;
    if ({underrun, sample_out} !== {1'b1, 18'd0}) begin
      n_fail++; $display("FAIL underrun_set: got underrun=%b sample_out=%0d required 1/0",
                         underrun, sample_out);
    end
  endtask

  task automatic test_frame_err();
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) begin
      in_frame[i] = DW'($urandom);
      strobe(in_frame[i]);
    end
    collect_fwd(ok);
    for (int i = 0; i < N; i++) inv_frame[i] = cap_data[i];
    send_inv(5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ferr_inv_timeout: got %0b required 1", ok); end
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b required 1", frame_err); end
    n_checks++;
    if (inv_ready !== 1'b0) begin
      n_fail++; $display("FAIL ferr_closed: got inv_ready=%b required 0", inv_ready);
    end
    for (int i = 0; i < N; i++) begin
      strobe(DW'($urandom));
      n_checks++;
      if (sample_out !== in_frame[i]) begin
        n_fail++; $display("FAIL ferr_play[%0d]: got %0d required %0d", i, sample_out, in_frame[i]);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    int w;
    do_reset();
    fwd_ready = 1'b0;
    for (int i = 0; i < 3 * N; i++) strobe(DW'(50 + i));
    fwd_ready = 1'b1;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_fwd_valid: got %b required 0", fwd_valid);
    end
    n_checks++;
    if ({sample_out, fwd_data, fwd_last, inv_ready, overrun, underrun, frame_err} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got overrun=%b fwd_data=%0d inv_ready=%b required 0",
                         overrun, fwd_data, inv_ready);
    end
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      in_frame[i] = DW'(101 + i);
      strobe(in_frame[i]);
    end
    w = 0;
    collect_fwd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_fresh_timeout: got %0b required 1", ok); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cap_data[i] !== in_frame[i]) begin
        n_fail++; $display("FAIL rst_fresh_fwd[%0d]: got %0d required %0d", i, cap_data[i], in_frame[i]);
      end
      inv_frame[i] = cap_data[i];
    end
    send_inv(N - 1, ok);
    for (int i = 0; i < N; i++) begin
      strobe(DW'($urandom));
      n_checks++;
      if (sample_out !== in_frame[i]) begin
        n_fail++; $display("FAIL rst_fresh_play[%0d]: got %0d required %0d", i, sample_out, in_frame[i]);
      end
      w++;
    end
  endtask

  // Streams several random frames back to back with a random exponent pair per frame.
  task automatic test_back_to_back();
    bit ok;
    int fs, isc;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      for (int i = 0; i < N; i++) begin
        in_frame[i] = DW'($urandom);
        strobe(in_frame[i]);
        if (k > 0) begin
          n_checks++;
          if (sample_out !== exp_frame[i]) begin
            n_fail++; $display("FAIL b2b_play[%0d][%0d]: got %0d required %0d", k - 1, i,
                               $signed(sample_out), $signed(exp_frame[i]));
          end
        end
      end
      if (k < 5) begin
        collect_fwd(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_fwd_timeout[%0d]: got %0b required 1", k, ok); end
        for (int i = 0; i < N; i++) begin
          n_checks++;
          if (cap_data[i] !== in_frame[i]) begin
            n_fail++; $display("FAIL b2b_fwd[%0d][%0d]: got %0d required %0d", k, i,
                               cap_data[i], in_frame[i]);
          end
          inv_frame[i] = cap_data[i];
        end
        fs  = int'($urandom_range(0, 6));
        isc = int'($urandom_range(0, 2));
        fft_scale = SW'(fs); ifft_scale = SW'(isc);
        for (int i = 0; i < N; i++) exp_frame[i] = ref_rescale(in_frame[i], fs, isc);
        send_inv(N - 1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_inv_timeout[%0d]: got %0b required 1", k, ok); end
      end
    end
    n_checks++;
    if ({overrun, underrun, frame_err} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_flags: got %b required 000", {overrun, underrun, frame_err});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rescale();
    test_overrun();
    test_underrun();
    test_frame_err();
    test_reset_mid_send();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
